// File: rtl/button_encoder_if.sv
// Command handshake between button_encoder (master) and the mm:ss counter (slave).
// The master drives a one-cycle operation strobe; the slave answers with encoder_reset.
interface button_encoder_if;
  logic [1:0] operation;
  logic       encoder_reset;

  modport master (output operation, input  encoder_reset);
  modport slave  (input  operation, output encoder_reset);
endinterface

// File: rtl/button_encoder.sv
// Synchronises and debounces three push-buttons, encodes presses into one-cycle
// operation strobes for the counter, and auto-repeats minute-add while it is held.
module button_encoder #(
  parameter logic [29:0] DEBOUNCE_CYCLES = 30'd1000000,
  parameter logic [29:0] REPEAT_DELAY    = 30'd25000000,
  parameter logic [29:0] REPEAT_PERIOD   = 30'd10000000,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_madd,
  input  logic                    btn_sto0,
  input  logic                    btn_reset,
  button_encoder_if.master        cmd,
  output logic                    ack_err
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STO0  = 2'b01;
  localparam logic [1:0] OP_MADD  = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  // Button vector order: [0] minute-add, [1] seconds-to-zero, [2] clock-reset.
  localparam int B_MADD  = 0;
  localparam int B_STO0  = 1;
  localparam int B_RESET = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_LOW,
    S_HOLD
  } state_t;

  logic [2:0]  w_btn_raw;
  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_deb;
  logic [2:0]  r_press;
  logic [29:0] r_deb_cnt [3];

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_code;
  logic [1:0]  w_next_code;
  logic        r_repeated;
  logic        w_next_repeated;
  logic [29:0] r_cnt;
  logic        w_cnt_inc;
  logic        w_set_err;
  logic [1:0]  w_operation;
  logic [29:0] w_repeat_limit;
  logic [29:0] w_ack_limit;

  assign w_btn_raw      = {btn_reset, btn_sto0, btn_madd};
  assign w_repeat_limit = r_repeated ? REPEAT_PERIOD : REPEAT_DELAY;
  assign w_ack_limit    = {14'd0, ACK_TIMEOUT};

  // A press event is a single-cycle pulse registered on the debounced 0->1 flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      // NOTE: the debounce counters are a handful of flops, not a RAM, so they reset like any other state.
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] + 30'd1 == DEBOUNCE_CYCLES) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
          r_press[i]   <= r_sync2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 30'd1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next_state    = r_state;
    w_next_code     = r_code;
    w_next_repeated = r_repeated;
    w_cnt_inc       = 1'b0;
    w_set_err       = 1'b0;
    w_operation     = OP_NOP;

    unique case (r_state)
      S_IDLE: begin
        if (r_press[B_RESET]) begin
          w_next_code  = OP_RESET;
          w_next_state = S_ISSUE;
        end else if (r_press[B_STO0]) begin
          w_next_code  = OP_STO0;
          w_next_state = S_ISSUE;
        end else if (r_press[B_MADD]) begin
          w_next_code  = OP_MADD;
          w_next_state = S_ISSUE;
        end
        w_next_repeated = 1'b0;
      end
      S_ISSUE: begin
        w_operation  = r_code;
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (cmd.encoder_reset) begin
          w_next_state = S_WAIT_LOW;
        end else if (r_cnt + 30'd1 == w_ack_limit) begin
          w_set_err    = 1'b1;
          w_next_state = S_HOLD;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!cmd.encoder_reset) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        // Other buttons are ignored here until everything is released.
        if (r_deb == 3'b000) begin
          w_next_state = S_IDLE;
        end else if (r_code == OP_MADD && r_deb[B_MADD]) begin
          if (r_cnt + 30'd1 == w_repeat_limit) begin
            w_next_repeated = 1'b1;
            w_next_state    = S_ISSUE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_code     <= OP_NOP;
      r_repeated <= 1'b0;
      r_cnt      <= '0;
      ack_err    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_code     <= w_next_code;
      r_repeated <= w_next_repeated;
      if (w_next_state != r_state) r_cnt <= '0;
      else if (w_cnt_inc)          r_cnt <= r_cnt + 30'd1;
      if (w_set_err) ack_err <= 1'b1;
    end
  end

  // Decoded straight from the state register, so the strobe is exactly the ISSUE cycle.
  assign cmd.operation = w_operation;

endmodule

// File: tb/tb_button_encoder.sv
// Directed bench for button_encoder: stimulus pushes expected strobes (cycle, code)
// into a queue; a negedge monitor pops and compares every non-zero operation.
module tb_button_encoder;

  logic clk = 1'b0;
  logic rst;
  logic btn_madd;
  logic btn_sto0;
  logic btn_reset;
  logic ack_err;
  logic ack_en;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];

  button_encoder_if bus ();

  button_encoder #(
    .DEBOUNCE_CYCLES (30'd4),
    .REPEAT_DELAY    (30'd20),
    .REPEAT_PERIOD   (30'd8),
    .ACK_TIMEOUT     (16'd6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_madd  (btn_madd),
    .btn_sto0  (btn_sto0),
    .btn_reset (btn_reset),
    .cmd       (bus),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer model: registered acknowledge, high the cycle after a strobe.
  always @(posedge clk) begin
    if (rst) bus.encoder_reset <= 1'b0;
    else     bus.encoder_reset <= ack_en && (bus.operation != 2'b00);
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.operation !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got operation=%b at cycle %0d, expected none", bus.operation, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_code", int'(bus.operation), int'(e.code));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_strobe(input int delta, input logic [1:0] code);
    exp_t e;
    e.cyc  = cyc + delta;
    e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [5:0] bounce;
    bounce    = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
    rst       = 1'b1;
    btn_madd  = 1'b0;
    btn_sto0  = 1'b0;
    btn_reset = 1'b0;
    ack_en    = 1'b1;
    tick(3);
    check("reset_operation", int'(bus.operation), 0);
    check("reset_ack_err", int'(ack_err), 0);
    rst = 1'b0;
    tick(2);

    // Clean minute-add press held 12 cycles.
    btn_madd = 1'b1;
    expect_strobe(7, 2'b10);
    tick(12);
    btn_madd = 1'b0;
    tick(12);
    check("s1_ack_err", int'(ack_err), 0);
    check("s1_ack_low", int'(bus.encoder_reset), 0);
    check_drained("s1_drained");

    // Bouncing seconds-to-zero; the last 1 starts the stable run.
    for (int i = 0; i < 6; i++) begin
      btn_sto0 = bounce[i];
      if (i == 5) expect_strobe(7, 2'b01);
      tick(1);
    end
    tick(9);
    btn_sto0 = 1'b0;
    tick(14);
    check_drained("s2_drained");

    // Minute-add held 60 cycles: first strobe +7, first repeat 3+20 later,
    // then every 3+8; the +63 repeat precedes the debounced release at +66.
    btn_madd = 1'b1;
    expect_strobe(7, 2'b10);
    expect_strobe(30, 2'b10);
    expect_strobe(41, 2'b10);
    expect_strobe(52, 2'b10);
    expect_strobe(63, 2'b10);
    tick(60);
    btn_madd = 1'b0;
    tick(20);
    check_drained("s3_drained");

    // Reset and minute-add together: only 11, no repeat, madd needs a re-press.
    btn_reset = 1'b1;
    btn_madd  = 1'b1;
    expect_strobe(7, 2'b11);
    tick(40);
    btn_reset = 1'b0;
    btn_madd  = 1'b0;
    tick(12);
    check_drained("s4_drained_a");
    btn_madd = 1'b1;
    expect_strobe(7, 2'b10);
    tick(10);
    btn_madd = 1'b0;
    tick(14);
    check_drained("s4_drained_b");

    // Consumer never acks: ack_err rises at strobe+1+6 and stays until rst.
    ack_en   = 1'b0;
    btn_madd = 1'b1;
    expect_strobe(7, 2'b10);
    tick(10);
    btn_madd = 1'b0;
    tick(3);
    check("s5_ack_err_before", int'(ack_err), 0);
    tick(1);
    check("s5_ack_err_set", int'(ack_err), 1);
    tick(6);
    ack_en   = 1'b1;
    btn_sto0 = 1'b1;
    expect_strobe(7, 2'b01);
    tick(10);
    btn_sto0 = 1'b0;
    tick(12);
    check("s5_ack_err_sticky", int'(ack_err), 1);
    check_drained("s5_drained");
    rst = 1'b1;
    tick(1);
    check("s5_ack_err_cleared", int'(ack_err), 0);
    rst = 1'b0;
    tick(2);

    // rst during WAIT_ACK with the button still held: re-issued after debounce.
    btn_sto0 = 1'b1;
    expect_strobe(7, 2'b01);
    tick(8);
    rst = 1'b1;
    tick(1);
    check("s6_rst_operation", int'(bus.operation), 0);
    check("s6_rst_ack_err", int'(ack_err), 0);
    rst = 1'b0;
    expect_strobe(7, 2'b01);
    tick(12);
    btn_sto0 = 1'b0;
    tick(12);
    check("s6_ack_err", int'(ack_err), 0);
    check_drained("s6_drained");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
